portin_deser: RTL and testbench



---
 rtl/portin_deser.sv | 189 ++++++++++++++++++
 tb/tb_portin_deser.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/portin_deser.sv
// Bit-serial router input port: deserialises frame_n/valid_n/di frames into an
// address/payload word held in a one-entry valid/ready register, with error and overflow stats.
module portin_deser #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              frame_n,
    input  logic              valid_n,
    input  logic              di,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_payload,
    output logic              err,
    output logic              ovf,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  ovf_cnt
);
    // state | meaning
    // IDLE  | between frames, waiting for an address or stray bit
    // ADDR  | collecting address bits (extra bits are padding)
    // PAY   | collecting payload bits until the last-bit cycle
    // DROP  | malformed frame, waiting for frame_n to return high
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_PAY, S_DROP} state_t;

    localparam int AW = $clog2(ADDR_W + 1);
    localparam int PW = $clog2(DATA_W + 2);
    localparam logic [AW-1:0] ACNT_FULL = AW'(ADDR_W);
    localparam logic [PW-1:0] PCNT_LAST = PW'(DATA_W - 1);
    localparam logic [PW-1:0] PCNT_CAP  = PW'(DATA_W);
    localparam logic [PW-1:0] PCNT_MAX  = PW'(DATA_W + 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_sr, addr_in;
    logic [DATA_W-1:0] pay_sr, pay_in;
    logic [AW-1:0]     acnt_q;
    logic [PW-1:0]     pcnt_q;
    logic              err_d, good_d, ovf_d, load;
    logic              addr_start, addr_step, pay_start, pay_step;
    logic              is_addr, is_pay, is_last;

    assign is_addr = !frame_n && valid_n;
    assign is_pay  = !frame_n && !valid_n;
    assign is_last = frame_n && !valid_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else if (clear)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        err_d      = 1'b0;
        good_d     = 1'b0;
        addr_start = 1'b0;
        addr_step  = 1'b0;
        pay_start  = 1'b0;
        pay_step   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_addr) begin
                    addr_start = 1'b1;
                    state_d    = S_ADDR;
                end else if (is_pay) begin
                    err_d   = 1'b1;
                    state_d = S_DROP;
                end else if (is_last) begin
                    err_d = 1'b1;
                end
            end
            S_ADDR: begin
                if (is_addr) begin
                    addr_step = 1'b1;
                end else if (is_pay) begin
                    if (acnt_q == ACNT_FULL) begin
                        pay_start = 1'b1;
                        state_d   = S_PAY;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DROP;
                    end
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_PAY: begin
                if (is_pay) begin
                    pay_step = 1'b1;
                end else if (is_last) begin
                    // pcnt counts bits already taken; the last bit makes pcnt+1
                    if (pcnt_q == PCNT_LAST)
                        good_d = 1'b1;
                    else
                        err_d = 1'b1;
                    state_d = S_IDLE;
                end else if (is_addr) begin
                    err_d   = 1'b1;
                    state_d = S_DROP;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DROP: begin
                if (frame_n)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // LSB-first shift-in at the MSB end: after exactly W shifts bit 0 lands at index 0
    assign addr_in = (addr_sr >> 1) | (ADDR_W'(di) << (ADDR_W - 1));
    assign pay_in  = (pay_sr >> 1) | (DATA_W'(di) << (DATA_W - 1));
    assign load    = good_d && (!out_valid || out_ready);
    assign ovf_d   = good_d && out_valid && !out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_sr     <= '0;
            pay_sr      <= '0;
            acnt_q      <= '0;
            pcnt_q      <= '0;
            out_valid   <= 1'b0;
            out_addr    <= '0;
            out_payload <= '0;
            err         <= 1'b0;
            ovf         <= 1'b0;
            err_cnt     <= '0;
            ovf_cnt     <= '0;
        end else if (clear) begin
            addr_sr     <= '0;
            pay_sr      <= '0;
            acnt_q      <= '0;
            pcnt_q      <= '0;
            out_valid   <= 1'b0;
            out_addr    <= '0;
            out_payload <= '0;
            err         <= 1'b0;
            ovf         <= 1'b0;
            err_cnt     <= '0;
            ovf_cnt     <= '0;
        end else begin
            if (addr_start) begin
                addr_sr <= ADDR_W'(di) << (ADDR_W - 1);
                pay_sr  <= '0;
                acnt_q  <= AW'(1);
            end else if (addr_step && acnt_q != ACNT_FULL) begin
                addr_sr <= addr_in;
                acnt_q  <= acnt_q + AW'(1);
            end

            if (pay_start) begin
                pay_sr <= pay_in;
                pcnt_q <= PW'(1);
            end else if (pay_step) begin
                if (pcnt_q < PCNT_CAP)
                    pay_sr <= pay_in;
                if (pcnt_q != PCNT_MAX)
                    pcnt_q <= pcnt_q + PW'(1);
            end

            err <= err_d;
            ovf <= ovf_d;

            if (load) begin
                out_valid   <= 1'b1;
                out_addr    <= addr_sr;
                out_payload <= pay_in;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (err_d && err_cnt != '1)
                err_cnt <= err_cnt + CNT_W'(1);
            if (ovf_d && ovf_cnt != '1)
                ovf_cnt <= ovf_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_portin_deser.sv
// Randomised and directed bench for portin_deser against a frame-level reference model.
module tb_portin_deser;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clock = 1'b0;
    logic              reset, clear, frame_n, valid_n, di, out_ready;
    logic              out_valid, err, ovf;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_payload;
    logic [CNT_W-1:0]  err_cnt, ovf_cnt;

    portin_deser #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .clear(clear), .frame_n(frame_n),
        .valid_n(valid_n), .di(di), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_payload(out_payload), .err(err), .ovf(ovf),
        .err_cnt(err_cnt), .ovf_cnt(ovf_cnt)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // reference model: held frame plus event tallies
    logic              m_valid;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_pay;
    int                m_errs, m_ovfs;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_pay;
    int                rmode;   // 0 random, 1 always ready, 2 never ready, 3 ready only at completion

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int n);
        return (n > CMAX) ? CMAX : n;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_addr  = '0;
        m_pay   = '0;
        m_errs  = 0;
        m_ovfs  = 0;
    endtask

    task automatic check_counters();
        chk("err_cnt", 64'(err_cnt), 64'(sat(m_errs)));
        chk("ovf_cnt", 64'(ovf_cnt), 64'(sat(m_ovfs)));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_addr"}, 64'(out_addr), 64'd0);
        chk({tag, "_pay"}, 64'(out_payload), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_ovf"}, 64'(ovf), 64'd0);
        chk({tag, "_errcnt"}, 64'(err_cnt), 64'd0);
        chk({tag, "_ovfcnt"}, 64'(ovf_cnt), 64'd0);
    endtask

    // one line cycle: drive, clock, update model, compare registered outputs
    task automatic tick(input logic fn, input logic vn, input logic d,
                        input logic exp_err, input logic good_end);
        logic rdy;
        logic exp_ovf;
        case (rmode)
            1:       rdy = 1'b1;
            2:       rdy = 1'b0;
            3:       rdy = good_end;
            default: rdy = 1'($urandom_range(0, 1));
        endcase
        frame_n = fn; valid_n = vn; di = d; out_ready = rdy;
        @(posedge clock); #1;
        exp_ovf = 1'b0;
        if (good_end && (!m_valid || rdy)) begin
            m_valid = 1'b1;
            m_addr  = cur_addr;
            m_pay   = cur_pay;
        end else if (good_end) begin
            exp_ovf = 1'b1;
            m_ovfs++;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (exp_err) m_errs++;
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("out_addr", 64'(out_addr), 64'(m_addr));
        chk("out_payload", 64'(out_payload), 64'(m_pay));
        chk("err", 64'(err), 64'(exp_err));
        chk("ovf", 64'(ovf), 64'(exp_ovf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // na address-cycle bits, np payload bits including the final frame_n=1 bit
    task automatic send_frame(input int na, input int np,
                              input logic [63:0] abits, input logic [63:0] pbits);
        logic good;
        int   dec;
        int   j;
        good = (na >= ADDR_W) && (np == DATA_W);
        if (good)             dec = -1;
        else if (na == 0)     dec = 0;
        else if (na < ADDR_W) dec = na;
        else                  dec = na + np - 1;
        cur_addr = abits[ADDR_W-1:0];
        cur_pay  = pbits[DATA_W-1:0];
        for (int i = 0; i < na + np; i++) begin
            if (i < na) begin
                tick(1'b0, 1'b1, abits[i], i == dec, 1'b0);
            end else begin
                j = i - na;
                tick((j == np - 1), 1'b0, pbits[j], i == dec,
                     good && (i == na + np - 1));
            end
        end
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; frame_n = 1'b1; valid_n = 1'b1; di = 1'b0;
        out_ready = 1'b0; rmode = 1;
        model_reset();
        #12;
        check_zero("reset");
        @(posedge clock); #1;
        reset = 1'b0;
        idle(2);

        // basic good frame, then padded address
        send_frame(4, 32, 64'hA, 64'hDEADBEEF);
        idle(1);
        check_counters();
        send_frame(6, 32, 64'h3A, 64'hDEADBEEF);
        idle(2);
        check_counters();

        // short then long
        send_frame(4, 31, 64'h5, 64'h12345678);
        idle(1);
        chk("short_errcnt", 64'(err_cnt), 64'd1);
        send_frame(4, 33, 64'h5, 64'h1_12345678);
        idle(1);
        chk("long_errcnt", 64'(err_cnt), 64'd2);

        // overflow with consumer stalled, then pop-and-load at completion
        rmode = 2;
        send_frame(4, 32, 64'h1, 64'h11111111);
        send_frame(4, 32, 64'h2, 64'h22222222);
        idle(1);
        chk("ovf_cnt1", 64'(ovf_cnt), 64'd1);
        rmode = 3;
        send_frame(4, 32, 64'h3, 64'h33333333);
        chk("popload_addr", 64'(out_addr), 64'h3);
        chk("popload_ovfcnt", 64'(ovf_cnt), 64'd1);
        rmode = 1;
        idle(1);

        // frame opening with a payload cycle, then a good frame
        send_frame(0, 10, 64'h0, 64'h3FF);
        send_frame(4, 32, 64'hC, 64'hCAFEF00D);
        idle(1);
        chk("drop_errcnt_sat", 64'(err_cnt), 64'd3);
        check_counters();

        // reset mid-payload
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        reset = 1'b1; frame_n = 1'b1; valid_n = 1'b1;
        #2;
        model_reset();
        check_zero("midreset");
        @(posedge clock); #1;
        reset = 1'b0;
        idle(1);

        // clear while a frame is held
        rmode = 2;
        send_frame(4, 32, 64'h9, 64'h99999999);
        send_frame(2, 5, 64'h0, 64'h0);
        idle(1);
        clear = 1'b1;
        frame_n = 1'b1; valid_n = 1'b1; out_ready = 1'b0;
        @(posedge clock); #1;
        clear = 1'b0;
        model_reset();
        check_zero("clear");
        rmode = 1;
        idle(1);

        // saturation of err_cnt with CNT_W=2
        for (int k = 0; k < 5; k++) begin
            send_frame(2, 1, 64'h0, 64'h0);
            chk("sat_errcnt", 64'(err_cnt), 64'(sat(m_errs)));
        end
        idle(1);

        // randomised frames, gaps and consumer behaviour
        rmode = 0;
        for (int f = 0; f < 200; f++) begin
            int na, np;
            na = $urandom_range(0, ADDR_W + 2);
            if ($urandom_range(0, 9) < 7) begin
                na = $urandom_range(ADDR_W, ADDR_W + 2);
                np = DATA_W;
            end else begin
                np = $urandom_range(1, DATA_W + 3);
            end
            send_frame(na, np, {$urandom, $urandom}, {$urandom, $urandom});
            idle($urandom_range(0, 2));
            check_counters();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
